mat_mult_seq: RTL

//  Sequencer computing a full 2x2 x 2x2 product C = A*B (2-bit unsigned entries) with the shared

---
 rtl/mat_mult_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mat_mult_seq.sv
// Sequencer for a 2x2 by 2x2 matrix product on a shared matrix-vector multiplier.
// Each column of B is issued as one pass, and the two result columns are returned together.
module mat_mult_seq #(
    parameter int MV_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mv_mat,
    output logic [3:0]  mv_vec,
    input  logic [9:0]  mv_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_c,
    output logic        busy,
    output logic [7:0]  done_cnt
);

    localparam int CW = (MV_LAT < 1) ? 1 : $clog2(MV_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MV_LAT);

    typedef enum logic [1:0] {
        IDLE,
        COL0,
        COL1,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    mv_mat_q, mv_mat_d;
    logic [3:0]    mv_vec_q, mv_vec_d;
    logic [9:0]    res0_q, res0_d;
    logic          out_valid_q, out_valid_d;
    logic [19:0]   out_c_q, out_c_d;
    logic [7:0]    done_cnt_q, done_cnt_d;

    // Multiplier inputs are registered and loaded one edge ahead of each pass,
    // so they are stable for the whole pass.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        mv_mat_d    = mv_mat_q;
        mv_vec_d    = mv_vec_q;
        res0_d      = res0_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    cnt_d    = '0;
                    mv_mat_d = in_a;
                    mv_vec_d = in_b[3:0];
                    state_d  = COL0;
                end
            end
            COL0: begin
                if (cnt_q == CNT_LAST) begin
                    res0_d   = mv_res;
                    cnt_d    = '0;
                    mv_mat_d = a_q;
                    mv_vec_d = b_q[7:4];
                    state_d  = COL1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COL1: begin
                if (cnt_q == CNT_LAST) begin
                    out_c_d     = {mv_res, res0_q};
                    out_valid_d = 1'b1;
                    mv_mat_d    = '0;
                    mv_vec_d    = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mv_mat_q    <= '0;
            mv_vec_q    <= '0;
            res0_q      <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mv_mat_q    <= mv_mat_d;
            mv_vec_q    <= mv_vec_d;
            res0_q      <= res0_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mv_mat    = mv_mat_q;
    assign mv_vec    = mv_vec_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign done_cnt  = done_cnt_q;

endmodule
